// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone (pipelined) arbiter: m0 = CPU, m1 = DMA/loader, round-robin on ties, ack watchdog.
// Latency: grant 1 cycle after cyc in IDLE; owner's requests and slave responses pass combinationally.
// Backpressure: owner sees slave stall; non-owner held stalled; grant held until owner drops cyc.
module wb_master_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_m0_cyc,
    input  logic            i_m0_stb,
    input  logic            i_m0_we,
    input  logic [AW-1:0]   i_m0_addr,
    input  logic [DW-1:0]   i_m0_data,
    input  logic [DW/8-1:0] i_m0_sel,
    input  logic            i_m1_cyc,
    input  logic            i_m1_stb,
    input  logic            i_m1_we,
    input  logic [AW-1:0]   i_m1_addr,
    input  logic [DW-1:0]   i_m1_data,
    input  logic [DW/8-1:0] i_m1_sel,
    output logic            o_m0_stall,
    output logic            o_m0_ack,
    output logic            o_m0_err,
    output logic [DW-1:0]   o_m0_data,
    output logic            o_m1_stall,
    output logic            o_m1_ack,
    output logic            o_m1_err,
    output logic [DW-1:0]   o_m1_data,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic [DW-1:0]   i_wb_data,
    output logic [1:0]      o_owner
);

    localparam int WDT_W = $clog2(TIMEOUT + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT - 1);
    localparam logic [WDT_W-1:0] WDT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t             state;
    logic               last_grant;  // 1 = m1 was granted last, so m0 wins the next tie
    logic               err_owner;   // master that timed out, 1 = m1
    logic [WDT_W-1:0]   wdt;

    logic gnt0, gnt1, own_cyc;

    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);

    always_comb begin
        own_cyc = 1'b0;
        if (gnt0)
            own_cyc = i_m0_cyc;
        else if (gnt1)
            own_cyc = i_m1_cyc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            err_owner  <= 1'b0;
            wdt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wdt <= '0;
                    if (i_m0_cyc && (!i_m1_cyc || last_grant)) begin
                        state      <= GNT0;
                        last_grant <= 1'b0;
                    end else if (i_m1_cyc) begin
                        state      <= GNT1;
                        last_grant <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    // Release beats timeout, and ack beats timeout.
                    if (!own_cyc) begin
                        state <= IDLE;
                        wdt   <= '0;
                    end else if (i_wb_ack) begin
                        wdt <= '0;
                    end else if (wdt == WDT_LAST) begin
                        state     <= ERR;
                        err_owner <= gnt1;
                        wdt       <= '0;
                    end else if (wdt != WDT_MAX) begin
                        wdt <= wdt + 1'b1;
                    end
                end
                ERR: begin
                    state <= IDLE;
                    wdt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_wb_cyc  = own_cyc;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_wb_sel  = '0;
        if (gnt0) begin
            o_wb_stb  = i_m0_cyc & i_m0_stb;
            o_wb_we   = i_m0_we;
            o_wb_addr = i_m0_addr;
            o_wb_data = i_m0_data;
            o_wb_sel  = i_m0_sel;
        end else if (gnt1) begin
            o_wb_stb  = i_m1_cyc & i_m1_stb;
            o_wb_we   = i_m1_we;
            o_wb_addr = i_m1_addr;
            o_wb_data = i_m1_data;
            o_wb_sel  = i_m1_sel;
        end
    end

    assign o_m0_stall = gnt0 ? i_wb_stall : 1'b1;
    assign o_m1_stall = gnt1 ? i_wb_stall : 1'b1;
    assign o_m0_ack   = gnt0 & i_wb_ack;
    assign o_m1_ack   = gnt1 & i_wb_ack;
    assign o_m0_data  = gnt0 ? i_wb_data : '0;
    assign o_m1_data  = gnt1 ? i_wb_data : '0;
    assign o_m0_err   = (state == ERR) && !err_owner;
    assign o_m1_err   = (state == ERR) &&  err_owner;
    assign o_owner    = {gnt1, gnt0};

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed table-driven bench for wb_master_arbiter with TIMEOUT=8.
module tb_wb_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 8;

    localparam logic [31:0] A0 = 32'h0000_C000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h2222_2222;
    localparam logic [3:0]  S0 = 4'hF;
    localparam logic [3:0]  S1 = 4'h3;
    localparam logic [31:0] RD = 32'hDEAD_BEEF;

    // expo = {owner, wb_cyc, wb_stb, wb_we, m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err}
    localparam logic [10:0] IDL = 11'b00_000_100_100;

    // stim = {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, wb_stall, wb_ack}
    typedef struct {
        logic [6:0]  stim;
        logic [10:0] expo;
        logic [31:0] addr;
    } vec_t;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_m0_cyc, i_m0_stb, i_m1_cyc, i_m1_stb;
    logic            i_wb_stall, i_wb_ack;
    logic            o_m0_stall, o_m0_ack, o_m0_err;
    logic            o_m1_stall, o_m1_ack, o_m1_err;
    logic [DW-1:0]   o_m0_data, o_m1_data;
    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW-1:0]   o_wb_data;
    logic [DW/8-1:0] o_wb_sel;
    logic [1:0]      o_owner;

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    wb_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_m0_cyc   (i_m0_cyc),
        .i_m0_stb   (i_m0_stb),
        .i_m0_we    (1'b1),
        .i_m0_addr  (A0),
        .i_m0_data  (D0),
        .i_m0_sel   (S0),
        .i_m1_cyc   (i_m1_cyc),
        .i_m1_stb   (i_m1_stb),
        .i_m1_we    (1'b0),
        .i_m1_addr  (A1),
        .i_m1_data  (D1),
        .i_m1_sel   (S1),
        .o_m0_stall (o_m0_stall),
        .o_m0_ack   (o_m0_ack),
        .o_m0_err   (o_m0_err),
        .o_m0_data  (o_m0_data),
        .o_m1_stall (o_m1_stall),
        .o_m1_ack   (o_m1_ack),
        .o_m1_err   (o_m1_err),
        .o_m1_data  (o_m1_data),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_wb_sel   (o_wb_sel),
        .i_wb_stall (i_wb_stall),
        .i_wb_ack   (i_wb_ack),
        .i_wb_data  (RD),
        .o_owner    (o_owner)
    );

    function automatic vec_t mk(input logic [6:0] s, input logic [10:0] e, input logic [31:0] a);
        vec_t v;
        v.stim = s;
        v.expo = e;
        v.addr = a;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance past the next edge.
    task automatic run_vec(input vec_t v, input string tag);
        logic [10:0] act;
        logic [35:0] e_bus;
        logic [63:0] e_mst;
        {i_rst, i_m0_cyc, i_m0_stb, i_m1_cyc, i_m1_stb, i_wb_stall, i_wb_ack} = v.stim;
        #3;
        act = {o_owner, o_wb_cyc, o_wb_stb, o_wb_we,
               o_m0_stall, o_m0_ack, o_m0_err, o_m1_stall, o_m1_ack, o_m1_err};
        case (v.expo[10:9])
            2'b01:   begin e_bus = {S0, D0}; e_mst = {RD, 32'h0}; end
            2'b10:   begin e_bus = {S1, D1}; e_mst = {32'h0, RD}; end
            default: begin e_bus = 36'h0;    e_mst = 64'h0;      end
        endcase
        chk({tag, " ctrl"}, 64'(act), 64'(v.expo));
        chk({tag, " addr"}, 64'(o_wb_addr), 64'(v.addr));
        chk({tag, " wb_sel_data"}, 64'({o_wb_sel, o_wb_data}), 64'(e_bus));
        chk({tag, " m_rdata"}, {o_m0_data, o_m1_data}, e_mst);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        {i_rst, i_m0_cyc, i_m0_stb, i_m1_cyc, i_m1_stb, i_wb_stall, i_wb_ack} = 7'b1_00_00_00;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;

        // Reset state, single m0 request with ack two cycles after grant
        tbl.push_back(mk(7'b0_00_00_00, IDL, 32'h0));
        tbl.push_back(mk(7'b0_11_00_00, IDL, 32'h0));
        tbl.push_back(mk(7'b0_11_00_00, 11'b01_111_000_100, A0));
        tbl.push_back(mk(7'b0_10_00_00, 11'b01_101_000_100, A0));
        tbl.push_back(mk(7'b0_10_00_01, 11'b01_101_010_100, A0));
        tbl.push_back(mk(7'b0_00_00_00, 11'b01_001_000_100, A0));
        tbl.push_back(mk(7'b0_00_00_00, IDL, 32'h0));
        // Reset restores last_grant=m1, so a tie goes to m0, then m1, then m0
        tbl.push_back(mk(7'b1_00_00_00, IDL, 32'h0));
        tbl.push_back(mk(7'b0_11_11_00, IDL, 32'h0));
        tbl.push_back(mk(7'b0_11_11_00, 11'b01_111_000_100, A0));
        tbl.push_back(mk(7'b0_10_11_01, 11'b01_101_010_100, A0));
        tbl.push_back(mk(7'b0_00_11_00, 11'b01_001_000_100, A0));
        tbl.push_back(mk(7'b0_00_11_00, IDL, 32'h0));
        tbl.push_back(mk(7'b0_00_11_00, 11'b10_110_100_000, A1));
        tbl.push_back(mk(7'b0_00_10_01, 11'b10_100_100_010, A1));
        tbl.push_back(mk(7'b0_00_00_00, 11'b10_000_100_000, A1));
        tbl.push_back(mk(7'b0_11_11_00, IDL, 32'h0));
        tbl.push_back(mk(7'b0_11_11_00, 11'b01_111_000_100, A0));
        tbl.push_back(mk(7'b0_00_11_00, 11'b01_001_000_100, A0));
        tbl.push_back(mk(7'b0_00_11_00, IDL, 32'h0));
        // m1 four-strobe burst, second stalled; m0 requests throughout
        tbl.push_back(mk(7'b0_11_11_00, 11'b10_110_100_000, A1));
        tbl.push_back(mk(7'b0_11_11_10, 11'b10_110_100_100, A1));
        tbl.push_back(mk(7'b0_11_11_01, 11'b10_110_100_010, A1));
        tbl.push_back(mk(7'b0_11_11_01, 11'b10_110_100_010, A1));
        tbl.push_back(mk(7'b0_11_11_01, 11'b10_110_100_010, A1));
        tbl.push_back(mk(7'b0_11_10_01, 11'b10_100_100_010, A1));
        tbl.push_back(mk(7'b0_11_00_00, 11'b10_000_100_000, A1));
        tbl.push_back(mk(7'b0_11_00_00, IDL, 32'h0));
        tbl.push_back(mk(7'b0_11_00_00, 11'b01_111_000_100, A0));
        tbl.push_back(mk(7'b0_00_00_00, 11'b01_001_000_100, A0));
        tbl.push_back(mk(7'b0_00_00_00, IDL, 32'h0));

        {i_rst, i_m0_cyc, i_m0_stb, i_m1_cyc, i_m1_stb, i_wb_stall, i_wb_ack} = 7'b1_00_00_00;
        repeat (2) @(posedge i_clk);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Watchdog: m1 never acked -> ERR on the 9th cycle after grant, then IDLE
        run_vec(mk(7'b0_00_11_00, IDL, 32'h0), "to_req");
        for (int k = 1; k <= 8; k++) begin
            v = mk({1'b0, 2'b00, 1'b1, k == 1, 2'b00},
                   {2'b10, 1'b1, k == 1, 1'b0, 3'b100, 3'b000}, A1);
            run_vec(v, $sformatf("to_gnt%0d", k));
        end
        run_vec(mk(7'b0_00_10_00, 11'b00_000_100_101, 32'h0), "to_err");
        run_vec(mk(7'b0_00_00_00, IDL, 32'h0), "to_idle");

        // Ack arriving on the last watchdog cycle wins: no ERR
        run_vec(mk(7'b0_11_00_00, IDL, 32'h0), "ak_req");
        for (int k = 1; k <= 8; k++) begin
            v = mk({1'b0, 1'b1, k == 1, 2'b00, 1'b0, k == 8},
                   {2'b01, 1'b1, k == 1, 1'b1, 1'b0, k == 8, 1'b0, 3'b100}, A0);
            run_vec(v, $sformatf("ak_gnt%0d", k));
        end
        run_vec(mk(7'b0_10_00_00, 11'b01_101_000_100, A0), "ak_hold");
        run_vec(mk(7'b0_00_00_00, 11'b01_001_000_100, A0), "ak_drop");
        run_vec(mk(7'b0_00_00_00, IDL, 32'h0), "ak_idle");

        // Owner drops cyc on the timeout cycle: back to IDLE without err
        run_vec(mk(7'b0_11_00_00, IDL, 32'h0), "dr_req");
        for (int k = 1; k <= 7; k++) begin
            v = mk({1'b0, 1'b1, k == 1, 4'b0000},
                   {2'b01, 1'b1, k == 1, 1'b1, 3'b000, 3'b100}, A0);
            run_vec(v, $sformatf("dr_gnt%0d", k));
        end
        run_vec(mk(7'b0_00_00_00, 11'b01_001_000_100, A0), "dr_drop");
        run_vec(mk(7'b0_00_00_00, IDL, 32'h0), "dr_noerr");

        // Reset mid m1 read aborts it; late slave ack is not routed; tie goes to m0
        run_vec(mk(7'b0_00_11_00, IDL, 32'h0), "rs_req");
        run_vec(mk(7'b0_00_11_00, 11'b10_110_100_000, A1), "rs_gnt");
        run_vec(mk(7'b1_00_10_00, 11'b10_100_100_000, A1), "rs_pulse");
        run_vec(mk(7'b0_11_11_01, IDL, 32'h0), "rs_after");
        run_vec(mk(7'b0_11_11_00, 11'b01_111_000_100, A0), "rs_tie");
        run_vec(mk(7'b0_00_00_00, 11'b01_001_000_100, A0), "rs_drop");
        run_vec(mk(7'b0_00_00_00, IDL, 32'h0), "rs_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; select width is DW/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum cycles a strobe may wait for ack; legal range is 2..65535.
REQ-004 i_clk  in  1  single clock; all state changes on the rising edge.
REQ-005 i_rst  in  1  reset, synchronous and active-high.
REQ-006 i_m0_cyc, i_m1_cyc  in  1  master bus-cycle request (m0 = CPU, m1 = DMA/loader).
REQ-007 i_m0_stb, i_m1_stb  in  1  master strobe.
REQ-008 i_m0_we, i_m1_we  in  1  master write enable.
REQ-009 i_m0_addr, i_m1_addr  in  AW  master address.
REQ-010 i_m0_data, i_m1_data  in  DW  master write data.
REQ-011 i_m0_sel, i_m1_sel  in  DW/8  master byte select.
REQ-012 o_m0_stall, o_m1_stall  out  1  stall to master.
REQ-013 o_m0_ack, o_m1_ack  out  1  ack to master.
REQ-014 o_m0_err, o_m1_err  out  1  timeout error to master, one-cycle pulse.
REQ-015 o_m0_data, o_m1_data  out  DW  read data to master.
REQ-016 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  shared slave-side bus controls.
REQ-017 o_wb_addr / o_wb_data / o_wb_sel  out  AW / DW / DW/8  shared slave-side bus.
REQ-018 i_wb_stall, i_wb_ack  in  1 each  slave stall and ack.
REQ-019 i_wb_data  in  DW  slave read data.
REQ-020 o_owner  out  2  current grant: 00 none, 01 m0, 10 m1.

Function
REQ-021 The state machine SHALL have states IDLE, GNT0, GNT1 and ERR.
REQ-022 In IDLE, if exactly one master has cyc high, the arbiter SHALL enter that master's GNT state at the next edge.
REQ-023 In IDLE, if both masters have cyc high, the arbiter SHALL grant the master not recorded in the last_grant register (round-robin).
REQ-024 last_grant SHALL be updated on every grant; after reset it indicates m1, so m0 wins the first tie.
REQ-025 Arbitration latency SHALL be exactly 1 cycle from cyc rising in IDLE to the slave-side cyc asserting.
REQ-026 While granted, the owner's stb/we/addr/data/sel SHALL drive the slave bus combinationally.
REQ-027 While granted, o_wb_cyc SHALL equal the owner's cyc.
REQ-028 While granted, the owner SHALL receive i_wb_stall, i_wb_ack and i_wb_data combinationally.
REQ-029 The non-owner SHALL see stall=1, ack=0 and err=0.
REQ-030 In IDLE and ERR, both masters SHALL see stall=1, ack=0 and err=0, except for the ERR pulse in REQ-037.
REQ-031 The grant SHALL be held while the owner's cyc is high; back-to-back pipelined strobes SHALL NOT be preempted.
REQ-032 When the owner drops cyc, o_wb_cyc and o_wb_stb SHALL drop in the same cycle and the state SHALL return to IDLE at that edge.
REQ-033 At least one IDLE cycle SHALL separate consecutive grants.
REQ-034 Watchdog counter wdt, width clog2(TIMEOUT+1), SHALL increment each granted cycle with owner cyc=1 and i_wb_ack=0.
REQ-035 wdt SHALL clear on i_wb_ack=1, on leaving a GNT state, and on reset.
REQ-036 wdt SHALL saturate and never wrap.
REQ-037 When wdt == TIMEOUT-1 and i_wb_ack=0, the next state SHALL be ERR; in ERR, o_wb_cyc=o_wb_stb=0, the owner's err=1 for exactly one cycle, then IDLE.
REQ-038 If ack and the timeout condition coincide, ack SHALL win: the ack is passed through, wdt clears and there is no ERR.
REQ-039 If the owner drops cyc in the same cycle as the timeout condition, the arbiter SHALL go to IDLE with no err.
REQ-040 o_wb_addr/data/sel/we SHALL be 0 when no master is granted.
REQ-041 o_owner SHALL reflect the registered state and read 00 in IDLE and ERR.

Reset
REQ-042 With i_rst=1 at an edge, the arbiter SHALL go to IDLE, set wdt=0 and set last_grant=m1.
REQ-043 The cycle after that edge, all slave outputs SHALL be 0, o_owner=00, both stalls=1 and all acks/errs=0.
REQ-044 Reset asserted mid-grant SHALL abort the transfer: o_wb_cyc falls the cycle after the reset edge, and no ack or err is produced.

Verification
REQ-045 Single request: m0 cyc+stb with addr=0x0000_C000 at t0 -> o_wb_cyc=1 with that addr at t0+1; slave ack at t0+3 -> o_m0_ack=1 at t0+3; m0 drops cyc -> o_owner=00 next cycle.
REQ-046 Tie after reset: both cyc rise together -> m0 granted; m0 finishes; m1 is still requesting -> m1 is granted after 1 IDLE cycle; a repeat tie then -> m0.
REQ-047 Pipelined burst: m1 issues 4 strobes with i_wb_stall=1 on the 2nd -> m1 stall mirrors it, all 4 acks are routed to m1, and m0 requesting throughout stays stalled with ack=0.
REQ-048 Timeout with TIMEOUT=8: slave never acks -> owner err pulses 1 cycle at cycle 9 after the first granted cycle, o_wb_cyc=0 during ERR, then IDLE.
REQ-049 Ack on the TIMEOUT-1 cycle -> ack is delivered and no err is produced.
REQ-050 Reset mid-grant: i_rst pulses during an m1 read -> next cycle o_owner=00, o_wb_cyc=0 and no ack/err; a subsequent tie is granted to m0.
